// File: rtl/scr1_dmem_router_np.sv
// SCR1 DMEM router: one core data port fanned out to PORT_NUM targets by mask/pattern decode,
// with an in-flight FIFO that keeps responses in issue order.
package scr1_memif_pkg;
  localparam int SCR1_DMEM_AWIDTH = 32;
  localparam int SCR1_DMEM_DWIDTH = 32;

  typedef enum logic [1:0] {
    SCR1_MEM_CMD_RD    = 2'b00,
    SCR1_MEM_CMD_WR    = 2'b01,
    SCR1_MEM_CMD_ERROR = 2'b11
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;
endpackage

module scr1_dmem_router_np
  import scr1_memif_pkg::*;
#(
  parameter int unsigned PORT_NUM    = 4,
  parameter int unsigned OUTSTANDING = 2,
  parameter logic [PORT_NUM-1:0][SCR1_DMEM_AWIDTH-1:0] PORT_ADDR_MASK    = {PORT_NUM{32'hFFFF0000}},
  parameter logic [PORT_NUM-1:0][SCR1_DMEM_AWIDTH-1:0] PORT_ADDR_PATTERN =
    {32'h00030000, 32'h00020000, 32'h00010000, 32'h00000000},
  parameter bit DEFAULT_PORT_EN = 1'b1
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           dmem_req,
  output logic                                           dmem_req_ack,
  input  type_scr1_mem_cmd_e                             dmem_cmd,
  input  type_scr1_mem_width_e                           dmem_width,
  input  logic [SCR1_DMEM_AWIDTH-1:0]                    dmem_addr,
  input  logic [SCR1_DMEM_DWIDTH-1:0]                    dmem_wdata,
  output logic [SCR1_DMEM_DWIDTH-1:0]                    dmem_rdata,
  output type_scr1_mem_resp_e                            dmem_resp,
  output logic [PORT_NUM-1:0]                            port_req,
  input  logic [PORT_NUM-1:0]                            port_req_ack,
  output type_scr1_mem_cmd_e   [PORT_NUM-1:0]            port_cmd,
  output type_scr1_mem_width_e [PORT_NUM-1:0]            port_width,
  output logic [PORT_NUM-1:0][SCR1_DMEM_AWIDTH-1:0]      port_addr,
  output logic [PORT_NUM-1:0][SCR1_DMEM_DWIDTH-1:0]      port_wdata,
  input  logic [PORT_NUM-1:0][SCR1_DMEM_DWIDTH-1:0]      port_rdata,
  input  type_scr1_mem_resp_e  [PORT_NUM-1:0]            port_resp
);

  localparam int IDX_W = $clog2(PORT_NUM + 1);
  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  // Pseudo-index for the internal error responder, one past the last real port.
  localparam logic [IDX_W-1:0] ERR_IDX = IDX_W'(PORT_NUM);

  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] last_sel;
  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] fifo_idx [OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             pop;
  logic             push;
  logic             can_issue;
  logic             tgt_ack;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Lowest matching non-zero port wins; port 0 is the match-or-default fallback.
  always_comb begin
    sel = ERR_IDX;
    for (int i = PORT_NUM - 1; i >= 1; i--) begin
      if ((dmem_addr & PORT_ADDR_MASK[i]) == PORT_ADDR_PATTERN[i]) sel = IDX_W'(i);
    end
    if ((sel == ERR_IDX) &&
        (DEFAULT_PORT_EN || ((dmem_addr & PORT_ADDR_MASK[0]) == PORT_ADDR_PATTERN[0])))
      sel = '0;
  end

  assign empty    = (count == '0);
  assign head_idx = fifo_idx[rd_ptr];

  always_comb begin
    dmem_resp  = SCR1_MEM_RESP_NOTRDY;
    dmem_rdata = '0;
    if (!empty) begin
      if (head_idx == ERR_IDX) begin
        dmem_resp = SCR1_MEM_RESP_RDY_ER;
      end else begin
        for (int i = 0; i < PORT_NUM; i++) begin
          if (head_idx == IDX_W'(i)) begin
            dmem_resp  = port_resp[i];
            dmem_rdata = port_rdata[i];
          end
        end
      end
    end
  end

  assign pop = !empty && ((dmem_resp == SCR1_MEM_RESP_RDY_OK) ||
                          (dmem_resp == SCR1_MEM_RESP_RDY_ER));

  // A change of target waits until every older request has answered, which keeps order.
  assign can_issue = ((count < CNT_W'(OUTSTANDING)) || pop) &&
                     (empty || (sel == last_sel) || ((count == CNT_W'(1)) && pop));

  always_comb begin
    tgt_ack = 1'b1;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (sel == IDX_W'(i)) tgt_ack = port_req_ack[i];
    end
  end

  assign dmem_req_ack = can_issue & tgt_ack;
  assign push         = dmem_req & dmem_req_ack;

  always_comb begin
    for (int i = 0; i < PORT_NUM; i++) begin
      if (sel == IDX_W'(i)) begin
        port_req[i]   = dmem_req & can_issue;
        port_cmd[i]   = dmem_cmd;
        port_width[i] = dmem_width;
        port_addr[i]  = dmem_addr;
        port_wdata[i] = dmem_wdata;
      end else begin
        port_req[i]   = 1'b0;
        port_cmd[i]   = SCR1_MEM_CMD_ERROR;
        port_width[i] = SCR1_MEM_WIDTH_ERROR;
        port_addr[i]  = '0;
        port_wdata[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last_sel <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= ptr_inc(wr_ptr);
        last_sel <= sel;
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // Entry payload is only read while count is non-zero, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_idx[wr_ptr] <= sel;
  end

`ifndef SYNTHESIS
  logic stray_resp;
  always_comb begin
    stray_resp = 1'b0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if ((port_resp[i] == SCR1_MEM_RESP_RDY_OK) || (port_resp[i] == SCR1_MEM_RESP_RDY_ER))
        stray_resp = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && !pop && (count == CNT_W'(OUTSTANDING))))
        else $error("push into full in-flight FIFO");
      assert (!(empty && stray_resp))
        else $error("target response with no request in flight");
      assert (!(dmem_req && $isunknown(sel)))
        else $error("unknown port select while request is active");
    end
  end
`endif

endmodule
